button_debounce: RTL and testbench

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/button_debounce.sv | 158 +++++++++++++++
 tb/tb_button_debounce.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//
// Per-channel debouncer for raw, bouncy, active-low push buttons. Each channel
// has a two-flop synchronizer, a four-state debounce FSM, and an optional
// auto-repeat generator that keeps emitting press pulses while the button is
// held.
//
// Parameters
//   BTN_COUNT    number of independent channels (bit 0 = up, bit 1 = down)
//   DEBOUNCE     debounce window is 2**DEBOUNCE clock cycles
//   REPEAT_DELAY cycles held before the first auto-repeat pulse
//   REPEAT_RATE  cycles between subsequent auto-repeat pulses
//   REPEAT_EN    1 = auto-repeat while held, 0 = one press per physical press
//
// Ports
//   clk           system clock, all state on the rising edge
//   rst           asynchronous active-high reset
//   btn_n         raw asynchronous buttons, active-low
//   level_n       debounced level, active-low
//   press         one-cycle pulse per debounced press and per auto-repeat
//   release_pulse one-cycle pulse per debounced release ("release" itself is a
//                 reserved word in SystemVerilog, hence the suffix)
// -----------------------------------------------------------------------------
module button_debounce #(
  parameter int          BTN_COUNT    = 2,
  parameter int          DEBOUNCE     = 21,
  parameter logic [23:0] REPEAT_DELAY = 24'd12_000_000,
  parameter logic [23:0] REPEAT_RATE  = 24'd3_000_000,
  parameter bit          REPEAT_EN    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BTN_COUNT-1:0] btn_n,
  output logic [BTN_COUNT-1:0] level_n,
  output logic [BTN_COUNT-1:0] press,
  output logic [BTN_COUNT-1:0] release_pulse
);

  typedef enum logic [1:0] {
    ST_RELEASED   = 2'd0,
    ST_DB_PRESS   = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_DB_RELEASE = 2'd3
  } state_t;

  localparam logic [DEBOUNCE-1:0] DB_LOAD    = {DEBOUNCE{1'b1}};
  localparam logic [DEBOUNCE-1:0] DB_ZERO    = {DEBOUNCE{1'b0}};
  localparam logic [DEBOUNCE-1:0] DB_ONE     = DEBOUNCE'(1'b1);
  localparam logic [23:0]         RPT_ZERO   = 24'd0;
  localparam logic [23:0]         RPT_ONE    = 24'd1;
  localparam logic [23:0]         DELAY_LOAD = REPEAT_DELAY - 24'd1;
  localparam logic [23:0]         RATE_LOAD  = REPEAT_RATE - 24'd1;

  for (genvar i = 0; i < BTN_COUNT; i++) begin : g_ch
    logic                meta_r;
    logic                sync_r;
    state_t              state_r;
    logic [DEBOUNCE-1:0] db_cnt_r;
    logic [23:0]         rpt_cnt_r;
    logic                level_n_r;
    logic                press_r;
    logic                release_r;

    // Two-flop synchronizer; idles at 1 (not pressed) out of reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        meta_r <= 1'b1;
        sync_r <= 1'b1;
      end else begin
        meta_r <= btn_n[i];
        sync_r <= meta_r;
      end
    end

    // Debounce FSM with auto-repeat; outputs are registered alongside state.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_r   <= ST_RELEASED;
        db_cnt_r  <= DB_ZERO;
        rpt_cnt_r <= RPT_ZERO;
        level_n_r <= 1'b1;
        press_r   <= 1'b0;
        release_r <= 1'b0;
      end else begin
        // Pulses are single-cycle unless a branch below re-asserts them.
        press_r   <= 1'b0;
        release_r <= 1'b0;
        case (state_r)
          ST_RELEASED: begin
            if (!sync_r) begin
              state_r  <= ST_DB_PRESS;
              db_cnt_r <= DB_LOAD;
            end else begin
              state_r  <= ST_RELEASED;
            end
          end

          ST_DB_PRESS: begin
            if (sync_r) begin
              // Glitch shorter than the window: silently drop it.
              state_r <= ST_RELEASED;
            end else if (db_cnt_r != DB_ZERO) begin
              db_cnt_r <= db_cnt_r - DB_ONE;
            end else begin
              state_r   <= ST_PRESSED;
              press_r   <= 1'b1;
              level_n_r <= 1'b0;
              rpt_cnt_r <= DELAY_LOAD;
            end
          end

          ST_PRESSED: begin
            if (sync_r) begin
              // Repeat counter is frozen while the release is being qualified
              // so a bounce back to pressed resumes the repeat timing.
              state_r  <= ST_DB_RELEASE;
              db_cnt_r <= DB_LOAD;
            end else if (REPEAT_EN) begin
              if (rpt_cnt_r == RPT_ZERO) begin
                press_r   <= 1'b1;
                rpt_cnt_r <= RATE_LOAD;
              end else begin
                rpt_cnt_r <= rpt_cnt_r - RPT_ONE;
              end
            end else begin
              rpt_cnt_r <= rpt_cnt_r;
            end
          end

          ST_DB_RELEASE: begin
            if (!sync_r) begin
              state_r <= ST_PRESSED;
            end else if (db_cnt_r != DB_ZERO) begin
              db_cnt_r <= db_cnt_r - DB_ONE;
            end else begin
              state_r   <= ST_RELEASED;
              level_n_r <= 1'b1;
              release_r <= 1'b1;
            end
          end

          default: begin
            state_r   <= ST_RELEASED;
            db_cnt_r  <= DB_ZERO;
            rpt_cnt_r <= RPT_ZERO;
            level_n_r <= 1'b1;
          end
        endcase
      end
    end

    assign level_n[i]       = level_n_r;
    assign press[i]         = press_r;
    assign release_pulse[i] = release_r;
  end

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;

  localparam int DB    = 3;
  localparam int WIN   = 1 << DB;
  localparam int DELAY = 20;
  localparam int RATE  = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn_n;

  // Index 0: auto-repeat instance, index 1: no-repeat instance.
  logic [1:0] o_level [2];
  logic [1:0] o_press [2];
  logic [1:0] o_rel   [2];

  button_debounce #(
    .BTN_COUNT(2), .DEBOUNCE(DB), .REPEAT_DELAY(24'd20),
    .REPEAT_RATE(24'd6), .REPEAT_EN(1'b1)
  ) dut_rep (
    .clk(clk), .rst(rst), .btn_n(btn_n),
    .level_n(o_level[0]), .press(o_press[0]), .release_pulse(o_rel[0])
  );

  button_debounce #(
    .BTN_COUNT(2), .DEBOUNCE(DB), .REPEAT_DELAY(24'd20),
    .REPEAT_RATE(24'd6), .REPEAT_EN(1'b0)
  ) dut_norep (
    .clk(clk), .rst(rst), .btn_n(btn_n),
    .level_n(o_level[1]), .press(o_press[1]), .release_pulse(o_rel[1])
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int k        = 0;

  // Behavioural model: counts consecutive synchronized samples against the
  // debounced level, and cumulative held time against repeat targets.
  logic       m_s1      [2][2];
  logic       m_s2      [2][2];
  logic       m_pressed [2][2];
  int         m_lo      [2][2];
  int         m_hi      [2][2];
  int         m_held    [2][2];
  int         m_target  [2][2];
  logic [1:0] exp_press [2];
  logic [1:0] exp_rel   [2];
  logic [1:0] exp_level [2];

  // Per-phase statistics from observed outputs.
  int pcnt   [2][2];
  int rcnt   [2][2];
  int pfirst [2][2];
  int rfirst [2][2];
  int pq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic model_reset_all();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        m_s1[d][c]      = 1'b1;
        m_s2[d][c]      = 1'b1;
        m_pressed[d][c] = 1'b0;
        m_lo[d][c]      = 0;
        m_hi[d][c]      = 0;
        m_held[d][c]    = 0;
        m_target[d][c]  = 0;
      end
      exp_press[d] = 2'b00;
      exp_rel[d]   = 2'b00;
      exp_level[d] = 2'b11;
    end
  endtask

  task automatic model_step();
    logic s;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        exp_press[d][c] = 1'b0;
        exp_rel[d][c]   = 1'b0;
        if (rst) begin
          m_s1[d][c] = 1'b1; m_s2[d][c] = 1'b1; m_pressed[d][c] = 1'b0;
          m_lo[d][c] = 0; m_hi[d][c] = 0; m_held[d][c] = 0; m_target[d][c] = 0;
        end else begin
          s          = m_s2[d][c];
          m_s2[d][c] = m_s1[d][c];
          m_s1[d][c] = btn_n[c];
          if (!m_pressed[d][c]) begin
            m_lo[d][c] = s ? 0 : m_lo[d][c] + 1;
            if (m_lo[d][c] == WIN + 1) begin
              exp_press[d][c] = 1'b1;
              m_pressed[d][c] = 1'b1;
              m_lo[d][c] = 0; m_hi[d][c] = 0; m_held[d][c] = 0;
              m_target[d][c] = DELAY;
            end
          end else if (s) begin
            m_hi[d][c]++;
            if (m_hi[d][c] == WIN + 1) begin
              exp_rel[d][c]   = 1'b1;
              m_pressed[d][c] = 1'b0;
              m_hi[d][c] = 0; m_lo[d][c] = 0;
            end
          end else if (m_hi[d][c] != 0) begin
            m_hi[d][c] = 0;
          end else begin
            m_held[d][c]++;
            if (d == 0 && m_held[d][c] == m_target[d][c]) begin
              exp_press[d][c] = 1'b1;
              m_target[d][c] += RATE;
            end
          end
        end
        exp_level[d][c] = ~m_pressed[d][c];
      end
    end
  endtask

  task automatic start_phase();
    k = 0;
    pq.delete();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        pcnt[d][c] = 0; rcnt[d][c] = 0; pfirst[d][c] = -1; rfirst[d][c] = -1;
      end
    end
  endtask

  // One clock: drive at negedge, step model at posedge, check at next negedge.
  task automatic cycle(input logic [1:0] b);
    btn_n = b;
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk(d == 0 ? "rep_level_n" : "norep_level_n", 32'(o_level[d]), 32'(exp_level[d]));
      chk(d == 0 ? "rep_press"   : "norep_press",   32'(o_press[d]), 32'(exp_press[d]));
      chk(d == 0 ? "rep_release" : "norep_release", 32'(o_rel[d]),   32'(exp_rel[d]));
      for (int c = 0; c < 2; c++) begin
        if (o_press[d][c] === 1'b1) begin
          pcnt[d][c]++;
          if (pfirst[d][c] < 0) pfirst[d][c] = k;
          if (d == 0 && c == 0) pq.push_back(k);
        end
        if (o_rel[d][c] === 1'b1) begin
          rcnt[d][c]++;
          if (rfirst[d][c] < 0) rfirst[d][c] = k;
        end
      end
    end
    k++;
    cyc++;
  endtask

  // Assert reset between edges and confirm outputs clear without a clock.
  task automatic async_reset();
    #2 rst = 1'b1;
    model_reset_all();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("async_rst_level_n", 32'(o_level[d]), 32'd3);
      chk("async_rst_press",   32'(o_press[d]), 32'd0);
      chk("async_rst_release", 32'(o_rel[d]),   32'd0);
    end
  endtask

  initial begin
    int         hold [2];
    logic [1:0] rb;

    rst   = 1'b1;
    btn_n = 2'b11;
    model_reset_all();
    @(negedge clk);
    repeat (3) cycle(2'b11);
    rst = 1'b0;
    repeat (5) cycle(2'b11);

    // Clean press on channel 0, then clean release.
    start_phase();
    repeat (40) cycle(2'b10);
    chk("clean_press_count", pq.size(), 32'd3);
    if (pq.size() == 3) begin
      chk("clean_press_edge", pq[0], 32'd10);
      chk("repeat1_edge",     pq[1], 32'd30);
      chk("repeat2_edge",     pq[2], 32'd36);
    end
    chk("norep_single_press", pcnt[1][0], 32'd1);
    chk("ch1_untouched",      pcnt[0][1], 32'd0);
    start_phase();
    repeat (15) cycle(2'b11);
    chk("clean_release_edge", rfirst[0][0], 32'd10);
    chk("clean_release_cnt",  rcnt[0][0],   32'd1);
    chk("no_press_on_rel",    pcnt[0][0],   32'd0);

    // Bouncing press, then bouncing release.
    start_phase();
    for (int i = 0; i < 3; i++) begin
      repeat (2) cycle(2'b10);
      repeat (2) cycle(2'b11);
    end
    repeat (20) cycle(2'b10);
    chk("bounce_press_cnt",  pcnt[0][0],   32'd1);
    chk("bounce_press_edge", pfirst[0][0], 32'd22);
    start_phase();
    repeat (3) cycle(2'b11);
    repeat (2) cycle(2'b10);
    repeat (20) cycle(2'b11);
    chk("bounce_rel_cnt",    rcnt[0][0],   32'd1);
    chk("bounce_rel_edge",   rfirst[0][0], 32'd15);
    chk("bounce_rel_nopress", pcnt[0][0],  32'd0);

    // Short glitch on channel 1.
    start_phase();
    repeat (3) cycle(2'b01);
    repeat (15) cycle(2'b11);
    chk("glitch_press", pcnt[0][1], 32'd0);
    chk("glitch_rel",   rcnt[0][1], 32'd0);
    chk("glitch_level", 32'(o_level[0][1]), 32'd1);

    // Reset with ch1 pressed and ch0 mid-debounce; then full re-debounce.
    repeat (12) cycle(2'b01);
    repeat (4) cycle(2'b00);
    async_reset();
    repeat (2) cycle(2'b00);
    rst = 1'b0;
    start_phase();
    repeat (15) cycle(2'b00);
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        chk("post_rst_press_edge", pfirst[d][c], 32'd10);
        chk("post_rst_press_cnt",  pcnt[d][c],   32'd1);
      end
    end
    repeat (15) cycle(2'b11);

    // Both held together: repeat vs no-repeat instances.
    start_phase();
    repeat (60) cycle(2'b00);
    chk("norep_ch0_cnt",  pcnt[1][0],   32'd1);
    chk("norep_ch1_cnt",  pcnt[1][1],   32'd1);
    chk("norep_ch0_edge", pfirst[1][0], 32'd10);
    chk("norep_ch1_edge", pfirst[1][1], 32'd10);
    chk("rep_ch1_cnt",    pcnt[0][1],   32'd6);
    start_phase();
    repeat (15) cycle(2'b11);
    chk("norep_rel0_edge", rfirst[1][0], 32'd10);
    chk("norep_rel1_edge", rfirst[1][1], 32'd10);
    chk("norep_rel0_cnt",  rcnt[1][0],   32'd1);
    chk("norep_rel1_cnt",  rcnt[1][1],   32'd1);

    // Randomized run lengths mixing glitches and long holds.
    rb   = 2'b11;
    hold = '{0, 0};
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (hold[c] == 0) begin
          rb[c]   = ~rb[c];
          hold[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5))
                                                : int'($urandom_range(6, 45));
        end
        hold[c]--;
      end
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
        cycle(rb);
        rst = 1'b0;
      end else begin
        cycle(rb);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
